// File: rtl/freq_meter_pkg.sv
// Shared types, range codes and helper functions for the frequency meter controller.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    GATE  = 2'd2,
    LATCH = 2'd3
  } state_e;

  localparam int unsigned RANGE_W = 2;

  localparam logic [RANGE_W-1:0] RANGE_1S    = 2'd0;
  localparam logic [RANGE_W-1:0] RANGE_100MS = 2'd1;
  localparam logic [RANGE_W-1:0] RANGE_10MS  = 2'd2;

  // Gate length in clock cycles for a range code.
  function automatic int unsigned gate_len(input logic [RANGE_W-1:0] rng,
                                           input int unsigned clk_freq);
    case (rng)
      RANGE_100MS: return clk_freq / 10;
      RANGE_10MS:  return clk_freq / 100;
      default:     return clk_freq;
    endcase
  endfunction

  // Range sequence 1 s -> 100 ms -> 10 ms -> 1 s; code 3 is never produced.
  function automatic logic [RANGE_W-1:0] next_range(input logic [RANGE_W-1:0] rng);
    if (rng == RANGE_10MS) return RANGE_1S;
    return RANGE_W'(rng + 2'd1);
  endfunction

endpackage

// File: rtl/freq_meter_ctrl_sig_edge_sync.sv
// Two-flop synchronizer plus registered rising-edge detector for an async input.
// Ports: clk, rst (sync, active-high), async_in (asynchronous level),
//        rise_pulse (one-cycle pulse, 3 cycles after the input rises).
module sig_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise_pulse
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic rise_q;

  // Synchronizer chain, previous-value register and registered edge pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= async_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      rise_q  <= sync2_q & ~prev_q;
    end
  end

  assign rise_pulse = rise_q;

endmodule

// File: rtl/freq_meter_ctrl.sv
// Frequency meter measurement sequencer: gate timing, edge counting, result latch.
// Ports: clk, rst (sync, active-high); start_pulse / range_pulse (one-cycle button
//        pulses); sig_in (async measured signal); range_sel (0=1 s,1=100 ms,2=10 ms);
//        gate_active (counting cycle); busy (ARM/GATE/LATCH); freq_count (last
//        latched count); result_valid (one-cycle latch pulse); overflow (last
//        result saturated).
module freq_meter_ctrl
  import freq_meter_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned COUNT_W    = 32,
  parameter bit          CONTINUOUS = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_pulse,
  input  logic               range_pulse,
  input  logic               sig_in,
  output logic [RANGE_W-1:0] range_sel,
  output logic               gate_active,
  output logic               busy,
  output logic [COUNT_W-1:0] freq_count,
  output logic               result_valid,
  output logic               overflow
);

  // Holds G-1 for the longest gate (CLK_FREQ cycles).
  localparam int unsigned GATE_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;

  localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};

  state_e              state_q,    state_d;
  logic [RANGE_W-1:0]  range_q,    range_d;
  logic [GATE_W-1:0]   gate_cnt_q, gate_cnt_d;
  logic [COUNT_W-1:0]  edge_cnt_q, edge_cnt_d;
  logic                ovf_int_q,  ovf_int_d;
  logic [COUNT_W-1:0]  freq_q,     freq_d;
  logic                overflow_q, overflow_d;
  logic                gate_active_q;
  logic                busy_q;
  logic                result_valid_q;
  logic                rise;

  sig_edge_sync u_sig_edge_sync (
    .clk        (clk),
    .rst        (rst),
    .async_in   (sig_in),
    .rise_pulse (rise)
  );

  // Next-state, range stepping, gate timer and edge counter.
  always_comb begin
    state_d    = state_q;
    range_d    = range_q;
    gate_cnt_d = gate_cnt_q;
    edge_cnt_d = edge_cnt_q;
    ovf_int_d  = ovf_int_q;
    freq_d     = freq_q;
    overflow_d = overflow_q;

    // Range may only change before the gate is loaded; a step in ARM feeds that load.
    if (range_pulse && ((state_q == IDLE) || (state_q == ARM))) begin
      range_d = next_range(range_q);
    end

    case (state_q)
      IDLE: begin
        if (start_pulse) state_d = ARM;
      end
      ARM: begin
        if (start_pulse) begin
          state_d = IDLE;
        end else begin
          edge_cnt_d = '0;
          gate_cnt_d = GATE_W'(gate_len(range_d, CLK_FREQ) - 32'd1);
          ovf_int_d  = 1'b0;
          state_d    = GATE;
        end
      end
      GATE: begin
        if (start_pulse) begin
          state_d = IDLE;
        end else begin
          // A rise arriving with the counter already at all-ones marks overflow.
          if (rise) begin
            if (edge_cnt_q == CNT_MAX) ovf_int_d  = 1'b1;
            else                       edge_cnt_d = edge_cnt_q + COUNT_W'(1);
          end
          if (gate_cnt_q == '0) state_d    = LATCH;
          else                  gate_cnt_d = gate_cnt_q - GATE_W'(1);
        end
      end
      LATCH: begin
        freq_d     = edge_cnt_q;
        overflow_d = ovf_int_q;
        // A start press here still lets the latch complete, then stops.
        if (CONTINUOUS && !start_pulse) state_d = ARM;
        else                            state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; status outputs are registered from state_d.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      range_q        <= RANGE_1S;
      gate_cnt_q     <= '0;
      edge_cnt_q     <= '0;
      ovf_int_q      <= 1'b0;
      freq_q         <= '0;
      overflow_q     <= 1'b0;
      gate_active_q  <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      range_q        <= range_d;
      gate_cnt_q     <= gate_cnt_d;
      edge_cnt_q     <= edge_cnt_d;
      ovf_int_q      <= ovf_int_d;
      freq_q         <= freq_d;
      overflow_q     <= overflow_d;
      gate_active_q  <= (state_d == GATE);
      busy_q         <= (state_d != IDLE);
      result_valid_q <= (state_d == LATCH);
    end
  end

  assign range_sel    = range_q;
  assign gate_active  = gate_active_q;
  assign busy         = busy_q;
  assign freq_count   = freq_q;
  assign result_valid = result_valid_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_freq_meter_ctrl.sv
// Directed bench for freq_meter_ctrl with CLK_FREQ=1000 (G = 1000/100/10 cycles).
module tb_freq_meter_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sig_in = 1'b0;
  logic tog_en = 1'b0;
  logic sig_lvl = 1'b0;

  always #5 clk = ~clk;

  // Measured signal: toggles every cycle (one rise per 2 cycles) or holds a level.
  always @(posedge clk) sig_in <= tog_en ? ~sig_in : sig_lvl;

  int n_checks = 0;
  int n_fails  = 0;

  // DUT a: single shot, 32-bit count.
  logic        start_a = 1'b0, range_a = 1'b0;
  logic [1:0]  range_sel_a;
  logic        ga_a, busy_a, rv_a, ovf_a;
  logic [31:0] fc_a;

  // DUT s: single shot, 3-bit count for saturation.
  logic        start_s = 1'b0, range_s = 1'b0;
  logic [1:0]  range_sel_s;
  logic        ga_s, busy_s, rv_s, ovf_s;
  logic [2:0]  fc_s;

  // DUT c: continuous re-arm.
  logic        start_c = 1'b0, range_c = 1'b0;
  logic [1:0]  range_sel_c;
  logic        ga_c, busy_c, rv_c, ovf_c;
  logic [31:0] fc_c;

  freq_meter_ctrl #(.CLK_FREQ(1000), .COUNT_W(32), .CONTINUOUS(1'b0)) dut_a (
    .clk(clk), .rst(rst), .start_pulse(start_a), .range_pulse(range_a), .sig_in(sig_in),
    .range_sel(range_sel_a), .gate_active(ga_a), .busy(busy_a), .freq_count(fc_a),
    .result_valid(rv_a), .overflow(ovf_a)
  );

  freq_meter_ctrl #(.CLK_FREQ(1000), .COUNT_W(3), .CONTINUOUS(1'b0)) dut_s (
    .clk(clk), .rst(rst), .start_pulse(start_s), .range_pulse(range_s), .sig_in(sig_in),
    .range_sel(range_sel_s), .gate_active(ga_s), .busy(busy_s), .freq_count(fc_s),
    .result_valid(rv_s), .overflow(ovf_s)
  );

  freq_meter_ctrl #(.CLK_FREQ(1000), .COUNT_W(32), .CONTINUOUS(1'b1)) dut_c (
    .clk(clk), .rst(rst), .start_pulse(start_c), .range_pulse(range_c), .sig_in(sig_in),
    .range_sel(range_sel_c), .gate_active(ga_c), .busy(busy_c), .freq_count(fc_c),
    .result_valid(rv_c), .overflow(ovf_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  int rv_n, rv_k, ga_n, bad_n;
  logic busy_k1, ga_k1;
  logic seen;

  initial begin
    // Reset with sig_in toggling.
    tog_en = 1'b1;
    rst = 1'b1;
    tick(); tick();
    chk("rst_range_a", 32'(range_sel_a), 0);
    chk("rst_fc_a",    fc_a, 0);
    chk("rst_rv_a",    32'(rv_a), 0);
    chk("rst_ovf_a",   32'(ovf_a), 0);
    chk("rst_ga_a",    32'(ga_a), 0);
    chk("rst_busy_a",  32'(busy_a), 0);
    chk("rst_fc_s",    32'(fc_s), 0);
    chk("rst_busy_c",  32'(busy_c), 0);
    rst = 1'b0;
    rv_n = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (rv_a || rv_s || rv_c || busy_a || busy_c) rv_n++;
    end
    chk("idle_no_activity", 32'(rv_n), 0);

    // Two range steps in IDLE -> 10 ms range, then a measurement.
    range_a = 1'b1; tick(); range_a = 1'b0; tick();
    range_a = 1'b1; tick(); range_a = 1'b0;
    chk("range_two_steps", 32'(range_sel_a), 2);
    start_a = 1'b1; tick(); start_a = 1'b0;   // now in cycle N+1
    rv_n = 0; rv_k = 0; ga_n = 0;
    busy_k1 = busy_a; ga_k1 = ga_a;
    if (ga_a) ga_n++;
    for (int k = 2; k <= 20; k++) begin
      tick();
      if (ga_a) ga_n++;
      if (rv_a) begin rv_n++; rv_k = k; end
    end
    chk("arm_busy",       32'(busy_k1), 1);
    chk("arm_no_gate",    32'(ga_k1), 0);
    chk("gate_cycles",    32'(ga_n), 10);
    chk("rv_count",       32'(rv_n), 1);
    chk("rv_cycle",       32'(rv_k), 12);
    chk("fc_10ms",        fc_a, 5);
    chk("ovf_10ms",       32'(ovf_a), 0);
    chk("idle_after_ss",  32'(busy_a), 0);

    // Saturation: 3-bit counter, 100 ms gate, 50 rises.
    range_s = 1'b1; tick(); range_s = 1'b0;
    chk("range_s_100ms", 32'(range_sel_s), 1);
    start_s = 1'b1; tick(); start_s = 1'b0;
    seen = 1'b0; rv_k = 0;
    for (int k = 2; k <= 150 && !seen; k++) begin
      tick();
      if (rv_s) begin seen = 1'b1; rv_k = k; end
    end
    chk("sat_rv_cycle", 32'(rv_k), 102);
    tick();
    chk("sat_fc",  32'(fc_s), 7);
    chk("sat_ovf", 32'(ovf_s), 1);

    // Abort five cycles into the gate; previous result must survive.
    start_a = 1'b1; tick(); start_a = 1'b0;   // k=1 ARM
    for (int k = 2; k <= 6; k++) tick();      // k=2..6 GATE
    chk("abort_pre_gate", 32'(ga_a), 1);
    start_a = 1'b1; tick(); start_a = 1'b0;   // k=7
    chk("abort_busy", 32'(busy_a), 0);
    chk("abort_gate", 32'(ga_a), 0);
    rv_n = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (rv_a || busy_a) rv_n++;
    end
    chk("abort_no_rv", 32'(rv_n), 0);
    chk("abort_fc_kept", fc_a, 5);

    // Continuous mode, sig_in held at 1: a result every 12 cycles, count 0.
    tog_en = 1'b0; sig_lvl = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    range_c = 1'b1; tick(); range_c = 1'b0; tick();
    range_c = 1'b1; tick(); range_c = 1'b0;
    start_c = 1'b1; tick(); start_c = 1'b0;   // k=1
    rv_n = 0; bad_n = 0;
    for (int k = 2; k <= 40; k++) begin
      if (k == 16) range_c = 1'b0;
      tick();
      if (k == 15) range_c = 1'b1;           // sampled at end of GATE cycle 15
      if (rv_c) begin
        rv_n++;
        if ((k % 12) != 0) bad_n++;
      end
      if (rv_c && (k > 12) && (fc_c != 0)) bad_n++;
    end
    range_c = 1'b0;
    chk("cont_rv_count",   32'(rv_n), 3);
    chk("cont_rv_period",  32'(bad_n), 0);
    chk("cont_range_hold", 32'(range_sel_c), 2);
    chk("cont_fc",         fc_c, 0);
    chk("cont_busy",       32'(busy_c), 1);
    start_c = 1'b1; tick(); start_c = 1'b0;
    chk("cont_abort", 32'(busy_c), 0);

    // Reset in the middle of a gate.
    tog_en = 1'b1;
    start_a = 1'b1; tick(); start_a = 1'b0;
    tick(); tick();
    chk("pre_rst_gate", 32'(ga_a), 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst_busy",  32'(busy_a), 0);
    chk("midrst_gate",  32'(ga_a), 0);
    chk("midrst_fc",    fc_a, 0);
    chk("midrst_range", 32'(range_sel_a), 0);
    chk("midrst_ovf_s", 32'(ovf_s), 0);
    tick();
    chk("midrst_stays_idle", 32'(busy_a), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/freq_meter_ctrl.md
Name: freq_meter_ctrl

Overview:
Measurement sequencer for the frequency meter. It takes one-cycle button pulses from the debounced one-shot button front end (start/stop and range), generates a counting gate of exact length, and counts rising edges of the measured signal inside the gate. At the end of each gate it latches the count as the displayed frequency result. It sits between the button front end and the display/BCD path.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz; sets the gate lengths.
COUNT_W, 32, width of the edge counter and the result.
CONTINUOUS, 1, 1 = re-arm automatically after each result; 0 = single shot.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
start_pulse  input  1  one-cycle pulse; starts a measurement, or aborts one in progress
range_pulse  input  1  one-cycle pulse; advances the gate range
sig_in  input  1  measured signal, asynchronous to clk
range_sel  output  2  current range: 0 = 1 s, 1 = 100 ms, 2 = 10 ms
gate_active  output  1  high during every counting cycle
busy  output  1  high in ARM, GATE and LATCH
freq_count  output  COUNT_W  last latched edge count
result_valid  output  1  one-cycle pulse when freq_count updates
overflow  output  1  the last latched result saturated

Behaviour:
- Reset: the following apply on any clock edge with rst=1, including mid-gate.
  - State goes to IDLE.
  - range_sel, freq_count, result_valid, overflow, gate_active and busy are all 0.
  - Internal counters and the synchronizer flops are 0.
- Gate length G per range: CLK_FREQ, CLK_FREQ/10 or CLK_FREQ/100 cycles (integer division). Code 3 is never reached.
- sig_in path:
  - Two-flop synchronizer, then an edge register.
  - A rise is detected when the synced value is 1 and the previous value was 0.
  - Input-to-detect latency is 3 cycles.
  - Detected rises count only while the state is GATE.
- FSM, with registered state:
  - IDLE: start_pulse -> ARM.
  - ARM (1 cycle): edge_cnt <= 0, gate_cnt <= G-1, ovf_int <= 0 -> GATE.
  - GATE: gate_active=1.
    - Each detected rise sets edge_cnt +1, saturating at all-ones; saturation sets ovf_int.
    - When gate_cnt==0 -> LATCH; otherwise gate_cnt decrements.
    - GATE therefore lasts exactly G cycles.
    - A rise detected in the last GATE cycle is counted.
  - LATCH (1 cycle): freq_count <= edge_cnt, overflow <= ovf_int, result_valid=1.
    - Next state is ARM if CONTINUOUS=1, else IDLE.
- Timing: start_pulse in cycle N gives ARM at N+1 and GATE at N+2..N+1+G. LATCH is at N+2+G, where result_valid is high and the new freq_count is visible from N+3+G.
- Abort: start_pulse while busy -> IDLE next cycle.
  - No result_valid is produced.
  - freq_count and overflow keep their previous values.
  - start_pulse in the LATCH cycle: the latch completes and result_valid pulses, then the state goes to IDLE.
- range_pulse: range_sel steps 0->1->2->0, and only in IDLE or ARM.
  - It is ignored in GATE and LATCH.
  - A change in ARM takes effect in that same ARM load.
- start_pulse and range_pulse in the same IDLE cycle: both are honoured, and the new range applies to this measurement.
- freq_count holds between results; it never clears except on rst.

Decomposition:
- Package freq_meter_pkg holds:
  - the state enum (IDLE, ARM, GATE, LATCH);
  - range code constants (RANGE_1S=0, RANGE_100MS=1, RANGE_10MS=2);
  - a gate_len(range, CLK_FREQ) function returning G.
- One sub-module, sig_edge_sync (clk, rst, async_in, rise_pulse): the 2FF synchronizer plus the rising-edge detector.
- The FSM, gate timer and edge counter stay in freq_meter_ctrl.

Test Plan:
All scenarios use CLK_FREQ=1000, so G is 1000, 100 or 10 cycles.
- Reset: assert rst for 2 cycles with sig_in toggling -> all outputs 0 and range_sel=0; no result_valid for 20 cycles without start.
- Two range_pulse in IDLE then start_pulse; sig_in toggles every cycle (one rise every 2 cycles) -> exactly 10 gate_active cycles, one result_valid at start+12, freq_count=5, overflow=0.
- COUNT_W=3, range 1 (G=100), sig_in toggling every cycle -> freq_count=7, overflow=1.
- CONTINUOUS=1, range 2, sig_in constant 1 -> result_valid every 12 cycles with freq_count=0; range_pulse during GATE leaves range_sel unchanged.
- Abort: start, then start_pulse again 5 cycles into the gate -> IDLE next cycle, no result_valid, freq_count keeps its prior value (e.g. 5).
- rst asserted mid-GATE -> next cycle IDLE, freq_count=0, gate_active=0, busy=0.
